// File: rtl/bcd_down_timer_pkg.sv
// Shared types and constants for the two-digit BCD countdown timer.
`timescale 1ns/1ps
package bcd_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int            BCD_W   = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  // Non-decimal nibbles clamp to 9 so the display never shows A-F.
  function automatic logic [BCD_W-1:0] bcd_sat(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_down_timer_if.sv
// Control/status bundle for bcd_down_timer; master drives commands, slave is the timer.
`timescale 1ns/1ps
interface bcd_down_timer_if;
  import bcd_timer_pkg::*;

  // load/start are single-cycle strobes and pause is a level, all sampled on the
  // rising clk edge with no ready/backpressure; status outputs are registered.
  logic       load;
  logic [7:0] load_val;
  logic       start;
  logic       pause;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       busy;
  logic       done;
  state_t     state;

  modport master (
    output load, load_val, start, pause,
    input  tens, ones, busy, done, state
  );

  modport slave (
    input  load, load_val, start, pause,
    output tens, ones, busy, done, state
  );

endinterface

// File: rtl/bcd_down_timer_digit.sv
// One decrementing BCD digit: load, 0->9 wrap on decrement, borrow-out when wrapping.
`timescale 1ns/1ps
module bcd_digit_dec
  import bcd_timer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [BCD_W-1:0] ld_val,
  input  logic             dec_en,
  output logic [BCD_W-1:0] q,
  output logic             borrow
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (ld) begin
      q <= ld_val;
    end else if (dec_en) begin
      q <= (q == '0) ? BCD_MAX : q - BCD_W'(1);
    end
  end

  assign borrow = dec_en & (q == '0);

endmodule

// File: rtl/bcd_down_timer.sv
// Two-digit BCD countdown timer stepping once every PRESCALE clocks.
// Optional periodic mode: define BCD_DOWN_TIMER_AUTO_RELOAD_EN.
`timescale 1ns/1ps
module bcd_down_timer
  import bcd_timer_pkg::*;
#(
  parameter int PRESCALE = 10
) (
  input logic           clk,
  input logic           rst,
  bcd_down_timer_if.slave bus
);

  localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  state_t        state;
  logic [PW-1:0] presc;
  logic [3:0]    tens, ones;
  logic          busy_q, done_q;
  logic          counting, step, expire, reload_now, ld_any;
  logic          ones_borrow, tens_borrow;
  logic [7:0]    sat_val, ld_digits;

  assign sat_val  = {bcd_sat(bus.load_val[7:4]), bcd_sat(bus.load_val[3:0])};
  // A PAUSE cycle with pause released counts, so each paused cycle costs exactly one clock.
  assign counting = ~bus.load & ((state == ST_RUN) | (state == ST_PAUSE)) & ~bus.pause;
  assign step     = counting & (presc == LAST);
  assign expire   = step & (tens == 4'd0) & (ones == 4'd1);
  assign ld_any   = bus.load | reload_now;

`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
  logic [7:0] reload_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reload_q <= 8'h00;
    end else if (bus.load) begin
      reload_q <= sat_val;
    end
  end

  assign reload_now = expire & (reload_q != 8'h00);
  assign ld_digits  = bus.load ? sat_val : reload_q;
`else
  assign reload_now = 1'b0;
  assign ld_digits  = sat_val;
`endif

  bcd_digit_dec u_ones (
    .clk    (clk),
    .rst    (rst),
    .ld     (ld_any),
    .ld_val (ld_digits[3:0]),
    .dec_en (step),
    .q      (ones),
    .borrow (ones_borrow)
  );

  bcd_digit_dec u_tens (
    .clk    (clk),
    .rst    (rst),
    .ld     (ld_any),
    .ld_val (ld_digits[7:4]),
    .dec_en (ones_borrow),
    .q      (tens),
    .borrow (tens_borrow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (bus.load || (state == ST_IDLE && bus.start)) begin
      presc <= '0;
    end else if (counting) begin
      presc <= step ? '0 : presc + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.load) begin
        state  <= ST_IDLE;
        busy_q <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            busy_q <= 1'b0;
            if (bus.start) begin
              if (tens != 4'd0 || ones != 4'd0) begin
                state  <= ST_RUN;
                busy_q <= 1'b1;
              end else begin
                state  <= ST_DONE;
                done_q <= 1'b1;
              end
            end
          end
          ST_RUN, ST_PAUSE: begin
            if (bus.pause) begin
              state  <= ST_PAUSE;
              busy_q <= 1'b1;
            end else if ((expire && !reload_now) || tens_borrow) begin
              // tens_borrow would mean stepping from 00; treat it as expiry too.
              state  <= ST_DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              state  <= ST_RUN;
              busy_q <= 1'b1;
              done_q <= reload_now;
            end
          end
          ST_DONE: begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
          default: begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.tens  = tens;
  assign bus.ones  = ones;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.state = state;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Self-checking bench for bcd_down_timer at PRESCALE=4; expected done edges are queued in exp_q.
`timescale 1ns/1ps
module tb_bcd_down_timer;
  import bcd_timer_pkg::*;

  localparam int P = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];

  bcd_down_timer_if bus();

  bcd_down_timer #(.PRESCALE(P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    logic [3:0] t, o;
    t = 4'(n / 10);
    o = 4'(n % 10);
    return {t, o};
  endfunction

  task automatic do_load(input logic [7:0] v);
    bus.load     = 1'b1;
    bus.load_val = v;
    tick();
    bus.load     = 1'b0;
  endtask

  task automatic do_start(output int e0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    e0 = cyc;
  endtask

  task automatic pop_and_check(input string name);
    logic [31:0] e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: done at edge %0d but no done expected", name, cyc);
    end else begin
      e = exp_q.pop_front();
      if (32'(cyc) !== e) begin
        n_fail++;
        $display("FAIL %s: done at edge %0d, expected edge %0d", name, cyc, e);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({bus.tens, bus.ones} !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got tens=%h ones=%h busy=%b done=%b, expected 0 0 0 0",
               bus.tens, bus.ones, bus.busy, bus.done);
    end
    n_tests++;
    if (bus.state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d expected %0d", bus.state, ST_IDLE);
    end
    rst = 1'b0;
    tick();
  endtask

  // Count n down; pause is high on edges [pause_at, pause_at+pause_len); start re-pulsed at restart_at.
  task automatic run_and_check(input int n, input bit do_ld, input int pause_at,
                               input int pause_len, input int restart_at, input string name);
    int e0, paused, counted, val, budget;
    bit seen;
    if (do_ld) begin
      do_load(to_bcd(n));
      n_tests++;
      if ({bus.tens, bus.ones} !== to_bcd(n)) begin
        n_fail++;
        $display("FAIL %s_load: digits %h%h expected %h", name, bus.tens, bus.ones, to_bcd(n));
      end
    end
    do_start(e0);
    exp_q.push_back(32'(e0 + n * P + pause_len));
    budget = n * P + pause_len + 8;
    seen = 1'b0;
    for (int r = 0; r <= budget && !seen; r++) begin
      paused = r - pause_at + 1;
      if (paused < 0) paused = 0;
      if (paused > pause_len) paused = pause_len;
      counted = r - paused;
      val = n - counted / P;
      if (val < 0) val = 0;
      n_tests++;
      if ({bus.tens, bus.ones} !== to_bcd(val)) begin
        n_fail++;
        $display("FAIL %s_digits: edge %0d digits %h%h expected %h", name, r, bus.tens, bus.ones, to_bcd(val));
      end
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        pop_and_check({name, "_done"});
      end else begin
        n_tests++;
        if (bus.busy !== 1'b1) begin
          n_fail++;
          $display("FAIL %s_busy: edge %0d busy %b expected 1", name, r, bus.busy);
        end
        bus.pause = (r + 1 >= pause_at) && (r + 1 < pause_at + pause_len);
        bus.start = (r + 1 == restart_at);
        tick();
      end
    end
    bus.pause = 1'b0;
    bus.start = 1'b0;
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: no done within %0d cycles, expected edge %0d", name, budget, n * P + pause_len);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    tick();
    n_tests++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.state !== ST_IDLE || {bus.tens, bus.ones} !== 8'h00) begin
      n_fail++;
      $display("FAIL %s_after: done=%b busy=%b state=%0d digits=%h%h expected 0 0 IDLE 00",
               name, bus.done, bus.busy, bus.state, bus.tens, bus.ones);
    end
  endtask

  task automatic test_abort_by_load();
    int e0;
    bit bad_done;
    do_load(8'h05);
    do_start(e0);
    bad_done = 1'b0;
    for (int r = 0; r <= 8; r++) begin
      if (bus.done === 1'b1) bad_done = 1'b1;
      if (r == 8) begin
        bus.load     = 1'b1;
        bus.load_val = 8'h20;
      end
      tick();
    end
    bus.load = 1'b0;
    n_tests++;
    if ({bus.tens, bus.ones} !== 8'h20 || bus.busy !== 1'b0 || bus.state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL abort_reload: digits=%h%h busy=%b state=%0d expected 20 0 IDLE",
               bus.tens, bus.ones, bus.busy, bus.state);
    end
    for (int r = 0; r < 30; r++) begin
      if (bus.done === 1'b1 || {bus.tens, bus.ones} !== 8'h20) bad_done = 1'b1;
      tick();
    end
    n_tests++;
    if (bad_done) begin
      n_fail++;
      $display("FAIL abort_no_done: got done or drift after abort, expected silent hold at 20");
    end
    run_and_check(20, 1'b0, 1000, 0, -1, "after_abort");
  endtask

  task automatic test_saturate();
    logic [7:0] vin[3] = '{8'hAF, 8'h3B, 8'hE4};
    logic [7:0] vexp[3] = '{8'h99, 8'h39, 8'h94};
    for (int i = 0; i < 3; i++) begin
      do_load(vin[i]);
      n_tests++;
      if ({bus.tens, bus.ones} !== vexp[i]) begin
        n_fail++;
        $display("FAIL saturate: load %h gave %h%h expected %h", vin[i], bus.tens, bus.ones, vexp[i]);
      end
    end
  endtask

  task automatic test_zero_start();
    int e0;
    do_load(8'h00);
    bus.start = 1'b1;
    exp_q.push_back(32'(cyc + 1));
    do_start(e0);
    if (bus.done === 1'b1) begin
      pop_and_check("zero_done");
    end else begin
      n_tests++;
      n_fail++;
      $display("FAIL zero_done: done %b after start edge, expected 1", bus.done);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    n_tests++;
    if (bus.busy !== 1'b0 || {bus.tens, bus.ones} !== 8'h00) begin
      n_fail++;
      $display("FAIL zero_busy: busy=%b digits=%h%h expected 0 00", bus.busy, bus.tens, bus.ones);
    end
    tick();
    n_tests++;
    if (bus.done !== 1'b0 || bus.state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL zero_after: done=%b state=%0d expected 0 IDLE", bus.done, bus.state);
    end
  endtask

  task automatic test_reset_mid_run();
    int e0;
    bit bad;
    do_load(8'h07);
    do_start(e0);
    tick();
    tick();
    n_tests++;
    if ({bus.tens, bus.ones} !== 8'h07 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre: digits=%h%h busy=%b expected 07 1", bus.tens, bus.ones, bus.busy);
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({bus.tens, bus.ones} !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL rstmid_async: digits=%h%h busy=%b done=%b state=%0d expected 00 0 0 IDLE",
               bus.tens, bus.ones, bus.busy, bus.done, bus.state);
    end
    tick();
    rst = 1'b0;
    bad = 1'b0;
    for (int r = 0; r < 40; r++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) bad = 1'b1;
      tick();
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL rstmid_quiet: saw done or busy after reset, expected none");
    end
  endtask

`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
  task automatic test_auto_reload();
    int e0, val;
    do_load(8'h02);
    do_start(e0);
    for (int k = 1; k <= 3; k++) exp_q.push_back(32'(e0 + 8 * k));
    for (int r = 0; r <= 26; r++) begin
      val = 2 - (r % 8) / P;
      n_tests++;
      if ({bus.tens, bus.ones} !== to_bcd(val) || bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL reload_digits: edge %0d digits %h%h busy %b expected %h 1",
                 r, bus.tens, bus.ones, bus.busy, to_bcd(val));
      end
      if (bus.done === 1'b1) pop_and_check("reload_done");
      tick();
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL reload_count: %0d done pulses missing, expected 0", exp_q.size());
      exp_q.delete();
    end
    do_load(8'h00);
    n_tests++;
    if (bus.busy !== 1'b0 || bus.state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reload_stop: busy=%b state=%0d expected 0 IDLE", bus.busy, bus.state);
    end
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    bus.load     = 1'b0;
    bus.load_val = 8'h00;
    bus.start    = 1'b0;
    bus.pause    = 1'b0;
    test_reset();
    test_saturate();
    test_zero_start();
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
    test_auto_reload();
`else
    run_and_check(12, 1'b1, 1000, 0, 20, "count_12");
    run_and_check(3, 1'b1, 5, 5, -1, "pause_3");
    test_abort_by_load();
`endif
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
